// File: rtl/ad5676r_pkg.sv
// Shared definitions for the AD5676R serial receive model: command codes,
// software-reset key, frame geometry and the receiver FSM state type.
package ad5676r_pkg;

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_WR_IN  = 4'h1;
  localparam logic [3:0] CMD_UPD    = 4'h2;
  localparam logic [3:0] CMD_WR_UPD = 4'h3;
  localparam logic [3:0] CMD_SWRST  = 4'h6;

  localparam logic [15:0] SWRST_KEY = 16'h1234;

  localparam int FRAME_BITS = 24;
  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE
  } rx_state_e;

endpackage

// File: rtl/ad5676r_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with an extra history
// flop that yields single-clk rise/fall pulses on the synchronised level.
module ad5676r_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall     = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/ad5676r_spi_rx.sv
// AD5676R serial-interface receiver: decodes writer frames and keeps the
// device's input/DAC register banks. Define AD5676R_LDAC_EN for the LDAC pin.
module ad5676r_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = ad5676r_pkg::FRAME_BITS,
  parameter int NUM_CH      = ad5676r_pkg::NUM_CH,
  parameter int DATA_W      = ad5676r_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     da_sclk,
  input  logic                     da_sdin,
  input  logic                     da_sync_inv,
`ifdef AD5676R_LDAC_EN
  input  logic                     da_ldac_inv,
`endif
  output logic                     frame_valid,
  output logic [3:0]               frame_cmd,
  output logic [3:0]               frame_addr,
  output logic [15:0]              frame_data,
  output logic                     frame_err,
  output logic                     cmd_ignored,
  output logic [NUM_CH*DATA_W-1:0] dac_out
);

  import ad5676r_pkg::*;

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = 5;
`ifdef AD5676R_LDAC_EN
  localparam int NUM_PINS = 4;
`else
  localparam int NUM_PINS = 3;
`endif

  logic [NUM_PINS-1:0] pin_vec, lvl_vec, rise_vec, fall_vec;

`ifdef AD5676R_LDAC_EN
  assign pin_vec = {da_ldac_inv, da_sync_inv, da_sdin, da_sclk};
`else
  assign pin_vec = {da_sync_inv, da_sdin, da_sclk};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin_sync
      ad5676r_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (pin_vec[gi]),
        .sync_out (lvl_vec[gi]),
        .rise     (rise_vec[gi]),
        .fall     (fall_vec[gi])
      );
    end
  endgenerate

  logic sclk_fall, sdin_lvl, sync_lvl, sync_rise, sync_fall;
  assign sclk_fall = fall_vec[0];
  assign sdin_lvl  = lvl_vec[1];
  assign sync_lvl  = lvl_vec[2];
  assign sync_rise = rise_vec[2];
  assign sync_fall = fall_vec[2];

  logic unused_edges;
`ifdef AD5676R_LDAC_EN
  logic ldac_fall;
  assign ldac_fall    = fall_vec[3];
  assign unused_edges = ^{rise_vec[0], lvl_vec[0], rise_vec[1], fall_vec[1],
                          rise_vec[3], lvl_vec[3]};
`else
  assign unused_edges = ^{rise_vec[0], lvl_vec[0], rise_vec[1], fall_vec[1]};
`endif

  rx_state_e              state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [FRAME_BITS-1:0]  shift_reg, shift_next;
  logic [3:0]             cmd_reg, addr_reg;
  logic [15:0]            data_reg;
  logic [DATA_W-1:0]      in_reg  [NUM_CH];
  logic [DATA_W-1:0]      dac_reg [NUM_CH];

  logic [3:0]  rx_cmd, rx_addr;
  logic [15:0] rx_data;
  logic [CH_W-1:0] rx_idx;
  logic frame_ok, addr_ok, do_wr_in, do_upd, do_swrst, ignore;

  assign rx_cmd  = shift_reg[23:20];
  assign rx_addr = shift_reg[19:16];
  assign rx_data = shift_reg[15:0];
  assign rx_idx  = rx_addr[CH_W-1:0];
  assign addr_ok = (int'(rx_addr) < NUM_CH);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    case (state_reg)
      ST_WAIT_HIGH: if (sync_lvl) state_next = ST_IDLE;
      ST_IDLE: begin
        if (sync_fall) begin
          cnt_next   = '0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A frame-end edge takes priority over a coincident sclk edge.
        if (sync_rise) begin
          state_next = ST_DECODE;
        end else if (sclk_fall) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], sdin_lvl};
          if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DECODE: state_next = ST_IDLE;
      default:   state_next = ST_WAIT_HIGH;
    endcase
  end

  always_comb begin
    frame_ok = (state_reg == ST_DECODE) && (cnt_reg == CNT_W'(FRAME_BITS));
    do_wr_in = 1'b0;
    do_upd   = 1'b0;
    do_swrst = 1'b0;
    ignore   = 1'b0;
    case (rx_cmd)
      CMD_NOP:    ;
      CMD_WR_IN:  if (addr_ok) do_wr_in = 1'b1; else ignore = 1'b1;
      CMD_UPD:    if (addr_ok) do_upd = 1'b1; else ignore = 1'b1;
      CMD_WR_UPD: if (addr_ok) begin do_wr_in = 1'b1; do_upd = 1'b1; end
                  else ignore = 1'b1;
      CMD_SWRST:  if (rx_data == SWRST_KEY) do_swrst = 1'b1; else ignore = 1'b1;
      default:    ignore = 1'b1;
    endcase
    if (!frame_ok) begin
      do_wr_in = 1'b0;
      do_upd   = 1'b0;
      do_swrst = 1'b0;
      ignore   = 1'b0;
    end
  end

  // Frame fields are presented live during the valid pulse, then held.
  assign frame_valid = frame_ok;
  assign frame_err   = (state_reg == ST_DECODE) && !frame_ok;
  assign cmd_ignored = ignore;
  assign frame_cmd   = frame_ok ? rx_cmd  : cmd_reg;
  assign frame_addr  = frame_ok ? rx_addr : addr_reg;
  assign frame_data  = frame_ok ? rx_data : data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_WAIT_HIGH;
      cnt_reg   <= '0;
      shift_reg <= '0;
      cmd_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        in_reg[i]  <= '0;
        dac_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      if (frame_ok) begin
        cmd_reg  <= rx_cmd;
        addr_reg <= rx_addr;
        data_reg <= rx_data;
      end
`ifdef AD5676R_LDAC_EN
      // LDAC copy first so a same-clk frame write overrides its channel.
      if (ldac_fall) begin
        for (int i = 0; i < NUM_CH; i++) dac_reg[i] <= in_reg[i];
      end
`endif
      if (do_swrst) begin
        for (int i = 0; i < NUM_CH; i++) begin
          in_reg[i]  <= '0;
          dac_reg[i] <= '0;
        end
      end
      if (do_wr_in) in_reg[rx_idx] <= rx_data;
      if (do_upd)   dac_reg[rx_idx] <= do_wr_in ? rx_data : in_reg[rx_idx];
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_dac_out
      assign dac_out[gi*DATA_W +: DATA_W] = dac_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_ad5676r_spi_rx.sv
// Directed bench for ad5676r_spi_rx: bit-bangs frames at sclk = clk/4 and
// compares decoded fields and DAC registers against hand-computed values.
module tb_ad5676r_spi_rx;

  logic         clk = 1'b0;
  logic         rst, da_sclk, da_sdin, da_sync_inv;
  logic         frame_valid, frame_err, cmd_ignored;
  logic [3:0]   frame_cmd, frame_addr;
  logic [15:0]  frame_data;
  logic [127:0] dac_out;
`ifdef AD5676R_LDAC_EN
  logic         da_ldac_inv = 1'b1;
`endif

  always #5 clk = ~clk;

  ad5676r_spi_rx dut (
    .clk         (clk),
    .rst         (rst),
    .da_sclk     (da_sclk),
    .da_sdin     (da_sdin),
    .da_sync_inv (da_sync_inv),
`ifdef AD5676R_LDAC_EN
    .da_ldac_inv (da_ldac_inv),
`endif
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .cmd_ignored (cmd_ignored),
    .dac_out     (dac_out)
  );

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  logic [3:0]  cap_cmd, cap_addr;
  logic [15:0] cap_data, cap_dac0;
  logic        cap_ign;
  logic [15:0] exp_dac [8];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_vec();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = exp_dac[i];
    return v;
  endfunction

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        valid_cnt++;
        cap_cmd  = frame_cmd;
        cap_addr = frame_addr;
        cap_data = frame_data;
        cap_ign  = cmd_ignored;
        cap_dac0 = dac_out[15:0];
      end
      if (frame_err) err_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits,
                            input int rst_at);
    $display("frame bits=%0d value=%0h rst_at=%0d", nbits, bits, rst_at);
    @(negedge clk);
    da_sync_inv = 1'b0;
    wait_clk(2);
    for (int i = 0; i < nbits; i++) begin
      da_sclk = 1'b1;
      da_sdin = bits[nbits-1-i];
      wait_clk(2);
      da_sclk = 1'b0;
      wait_clk(2);
      if (i == rst_at - 1) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
    end
    da_sclk = 1'b1;
    wait_clk(2);
    da_sync_inv = 1'b1;
    wait_clk(8);
  endtask

  int v0, e0;

  initial begin
    rst = 1'b1;
    da_sclk = 1'b1;
    da_sdin = 1'b0;
    da_sync_inv = 1'b1;
    for (int i = 0; i < 8; i++) exp_dac[i] = 16'h0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check("rst_valid", frame_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_cmd", frame_cmd, 0);
    check("rst_data", frame_data, 0);
    check("rst_dac", dac_out, 0);
    wait_clk(5);

    // Write-and-update ch0
    v0 = valid_cnt;
    send_frame(32'h30ABCD, 24, -1);
    check("t1_valid_cnt", valid_cnt - v0, 1);
    check("t1_cmd", cap_cmd, 4'h3);
    check("t1_addr", cap_addr, 4'h0);
    check("t1_data", cap_data, 16'hABCD);
    check("t1_ign", cap_ign, 0);
    check("t1_dac_during_valid", cap_dac0, 16'h0);
    exp_dac[0] = 16'hABCD;
    check("t1_dac", dac_out, exp_vec());
    check("t1_cmd_held", frame_cmd, 4'h3);

    // Input-only write then update
    send_frame(32'h151234, 24, -1);
    check("t2_dac_after_wr_in", dac_out, exp_vec());
    send_frame(32'h250000, 24, -1);
    exp_dac[5] = 16'h1234;
    check("t2_dac_after_upd", dac_out, exp_vec());
    check("t2_ch5", dac_out[95:80], 16'h1234);

    // Unsupported command
    v0 = valid_cnt;
    send_frame(32'hB38F09, 24, -1);
    check("t3_valid_cnt", valid_cnt - v0, 1);
    check("t3_cmd", cap_cmd, 4'hB);
    check("t3_addr", cap_addr, 4'h3);
    check("t3_data", cap_data, 16'h8F09);
    check("t3_ign", cap_ign, 1);
    check("t3_dac", dac_out, exp_vec());

    // Short and long frames
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(32'h000F1234, 20, -1);
    send_frame(32'h0030FFFF, 25, -1);
    check("t4_err_cnt", err_cnt - e0, 2);
    check("t4_valid_cnt", valid_cnt - v0, 0);
    check("t4_cmd_held", frame_cmd, 4'hB);
    check("t4_data_held", frame_data, 16'h8F09);
    check("t4_dac", dac_out, exp_vec());

    // Load all channels, then software reset
    for (int i = 0; i < 8; i++) begin
      send_frame({8'h0, 4'h3, 4'(i), 16'h1000 + 16'(i)}, 24, -1);
      exp_dac[i] = 16'h1000 + 16'(i);
    end
    check("t5_loaded", dac_out, exp_vec());
    send_frame(32'h601234, 24, -1);
    for (int i = 0; i < 8; i++) exp_dac[i] = 16'h0;
    check("t5_swrst_ign", cap_ign, 0);
    check("t5_swrst", dac_out, 0);
    send_frame(32'h220000, 24, -1);
    check("t5_input_cleared", dac_out, exp_vec());
    send_frame(32'h322222, 24, -1);
    exp_dac[2] = 16'h2222;
    check("t5_ch2", dac_out, exp_vec());
    send_frame(32'h605555, 24, -1);
    check("t5_badkey_ign", cap_ign, 1);
    check("t5_badkey_dac", dac_out, exp_vec());
    send_frame(32'h381234, 24, -1);
    check("t5_addr8_ign", cap_ign, 1);
    check("t5_addr8_addr", cap_addr, 4'h8);
    check("t5_addr8_dac", dac_out, exp_vec());

    // Reset in the middle of a frame
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(32'h37AAAA, 24, 12);
    for (int i = 0; i < 8; i++) exp_dac[i] = 16'h0;
    check("t6_valid_cnt", valid_cnt - v0, 0);
    check("t6_err_cnt", err_cnt - e0, 0);
    check("t6_cmd", frame_cmd, 4'h0);
    check("t6_dac", dac_out, exp_vec());
    send_frame(32'h371111, 24, -1);
    exp_dac[7] = 16'h1111;
    check("t6_clean_valid", valid_cnt - v0, 1);
    check("t6_clean_dac", dac_out, exp_vec());
    check("t6_ch7", dac_out[127:112], 16'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad5676r_spi_rx.md
Name: ad5676r_spi_rx

Overview:
- Receive-side model of the AD5676R serial interface: decodes the 3-wire frames (da_sclk, da_sdin, da_sync_inv) produced by the DAC writer back into command, address and data.
- Maintains 8 input registers and 8 DAC registers exactly as the device does.
- Used as the in-FPGA loopback checker and bench responder for the DAC write path, and as a register-level monitor on the XEM3001.
- Runs entirely on the system clock; serial pins are oversampled.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on each serial input (min 2).
- FRAME_BITS, 24, bits per valid frame.
- NUM_CH, 8, DAC channels.
- DATA_W, 16, code width per channel.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- da_sclk  in  1  serial clock from writer.
- da_sdin  in  1  serial data, MSB first, sampled on da_sclk falling edge.
- da_sync_inv  in  1  frame select, active-low.
- frame_valid  out  1  one-clk pulse: complete 24-bit frame decoded.
- frame_cmd  out  4  frame bits 23:20, held until next frame_valid.
- frame_addr  out  4  frame bits 19:16, held.
- frame_data  out  16  frame bits 15:0, held.
- frame_err  out  1  one-clk pulse: frame ended with bit count != FRAME_BITS.
- cmd_ignored  out  1  one-clk pulse, coincident with frame_valid: unsupported cmd or addr >= NUM_CH.
- dac_out  out  NUM_CH*DATA_W  DAC registers, flattened; ch0 in bits 15:0.

Behaviour:
- Reset values: all outputs, input registers and DAC registers 0; state WAIT_HIGH; bit counter 0.
- Serial inputs pass through SYNC_STAGES flops; one extra flop provides edge detection.
- Timing constraint: da_sclk high and low each >= 2 clk periods. Faster sclk is out of spec.
- FSM states:
  - WAIT_HIGH: ignore everything until synced sync_inv = 1, then go to IDLE. Reset never arms mid-frame.
  - IDLE: on synced sync_inv falling, clear the counter and go to SHIFT.
  - SHIFT: on each synced sclk falling edge, shift sdin into a 24-bit register (LSB in) and increment the counter; the counter saturates at 31.
  - SHIFT exit: on synced sync_inv rising, go to DECODE.
  - DECODE (one clk): evaluate the frame per the rules below, then go to IDLE.
- DECODE, count == 24: pulse frame_valid and latch the cmd/addr/data outputs.
- DECODE, count != 24 (short or long frame): pulse frame_err only; no register or frame_* change.
- Sync rising and sclk falling detected in the same clk: the sync edge wins and the sclk edge is dropped.
- Commands, addr n < NUM_CH:
  - 0x0: NOP.
  - 0x1: input[n] <= data.
  - 0x2: dac[n] <= input[n].
  - 0x3: input[n] <= data and dac[n] <= data.
- Command 0x6 with data 0x1234: software reset; all input and DAC registers cleared; addr is don't-care.
- Cmd 0x6 with any other data, any other cmd, or addr >= NUM_CH on cmds 0x1–0x3: cmd_ignored = 1 and registers unchanged. frame_valid still pulses.
- Latency: frame_valid and the register write occur in the clk after the synced sync_inv rising edge. The new dac_out is visible the following clk, i.e. SYNC_STAGES+2 clks after the pin edge.
- rst mid-frame: partial frame discarded, no frame_err, state WAIT_HIGH.

Optional Feature:
- Macro: AD5676R_LDAC_EN.
- Defined: adds input port da_ldac_inv (1 bit), synchronised like the other serial inputs.
  - A synced falling edge copies all input registers to the DAC registers in one clk.
  - If it coincides with DECODE, the LDAC copy is applied first and the frame write second; a cmd 0x3 value therefore wins for its channel.
- Undefined: port absent; DAC registers change only via cmd 0x2/0x3 or software reset.

Decomposition:
- Shared package ad5676r_pkg:
  - command encodings CMD_NOP=0x0, CMD_WR_IN=0x1, CMD_UPD=0x2, CMD_WR_UPD=0x3, CMD_SWRST=0x6;
  - SWRST_KEY=16'h1234;
  - FRAME_BITS, NUM_CH, DATA_W;
  - FSM state enum.
- One sub-module: ad5676r_sync_edge. A SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated once per serial input.

Test Plan:
- Frame 0x30ABCD, sclk = clk/4 → frame_valid once, cmd=3, addr=0, data=0xABCD; dac_out[15:0]=0xABCD next clk.
- Frame 0x151234, then 0x250000 → after frame 1 dac ch5 = 0; after frame 2 dac_out[95:80]=0x1234.
- Frame 24'b101100111000111100001001 (0xB38F09) → frame_valid, cmd=0xB, addr=3, data=0x8F09, cmd_ignored=1, all registers unchanged.
- 20-bit frame, then a 25-bit frame → two frame_err pulses, no frame_valid, frame_* outputs unchanged.
- Load ch0..ch7 via cmd 0x3, then frame 0x601234 → all dac_out = 0. Frame 0x605555 → cmd_ignored, values kept.
- rst pulsed after 12 bits with sync_inv still low, then the remaining bits, then a clean 0x371111 → no output for the broken frame; ch7 = 0x1111 after the clean frame.
